unidade_controle_seq: RTL and testbench

UNIDADE_CONTROLE_SEQ -- requirements
Module: unidade_controle_seq

---
 rtl/unidade_controle_seq.sv | 142 ++++++++++++++
 tb/tb_unidade_controle_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_seq.sv
// rtl/unidade_controle_seq.sv - sequence-memory game control FSM (optional timeout via TIMEOUT_EN)
module unidade_controle_seq #(
  parameter int TIMEOUT_CYCLES = 3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim_contagem,
  input  logic       fim_limite,
  output logic       zera_c,
  output logic       conta_c,
  output logic       zera_l,
  output logic       conta_l,
  output logic       registra,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    S_INICIAL        = 4'h0,
    S_PREPARACAO     = 4'h1,
    S_ESPERA         = 4'h2,
    S_REGISTRA       = 4'h3,
    S_COMPARACAO     = 4'h4,
    S_PROXIMO        = 4'h5,
    S_PROXIMO_LIMITE = 4'h6,
    S_FIM_ACERTO     = 4'hA,
    S_FIM_TIMEOUT    = 4'hD,
    S_FIM_ERRO       = 4'hE
  } estado_t;

  // A zero-cycle timeout has no meaning; refuse to elaborate it.
  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  estado_t    estado;
  estado_t    estado_nxt;
  logic       timeout;
  logic [7:0] saida_q;

`ifdef TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tmo_cnt;
  logic          tmo_q;

  // Count cycles spent waiting for a play; saturate so the counter never wraps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (estado != S_ESPERA) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_LAST) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout    = (estado == S_ESPERA) && (tmo_cnt == TMO_LAST);
  assign db_timeout = tmo_q;
`else
  assign timeout    = 1'b0;
  assign db_timeout = 1'b0;
`endif

  // Transition rules; a play always wins over a simultaneous timeout.
  function automatic estado_t proximo(estado_t e, logic ini, logic jog, logic ig,
                                      logic fc, logic fl, logic tmo);
    estado_t n;
    n = S_INICIAL;
    case (e)
      S_INICIAL:        n = ini ? S_PREPARACAO : S_INICIAL;
      S_PREPARACAO:     n = S_ESPERA;
      S_ESPERA:         n = jog ? S_REGISTRA : (tmo ? S_FIM_TIMEOUT : S_ESPERA);
      S_REGISTRA:       n = S_COMPARACAO;
      S_COMPARACAO: begin
        if (!ig)      n = S_FIM_ERRO;
        else if (!fc) n = S_PROXIMO;
        else if (!fl) n = S_PROXIMO_LIMITE;
        else          n = S_FIM_ACERTO;
      end
      S_PROXIMO:        n = S_ESPERA;
      S_PROXIMO_LIMITE: n = S_ESPERA;
      S_FIM_ACERTO:     n = ini ? S_PREPARACAO : S_FIM_ACERTO;
      S_FIM_ERRO:       n = ini ? S_PREPARACAO : S_FIM_ERRO;
`ifdef TIMEOUT_EN
      S_FIM_TIMEOUT:    n = ini ? S_PREPARACAO : S_FIM_TIMEOUT;
`endif
      default:          n = S_INICIAL;
    endcase
    return n;
  endfunction

  // Control/flag pattern for each state:
  // {zera_c, conta_c, zera_l, conta_l, registra, acertou, errou, pronto}
  function automatic logic [7:0] decodifica(estado_t e);
    logic [7:0] s;
    s = 8'h00;
    case (e)
      S_PREPARACAO:     s = 8'b1010_0000;
      S_REGISTRA:       s = 8'b0000_1000;
      S_PROXIMO:        s = 8'b0100_0000;
      S_PROXIMO_LIMITE: s = 8'b1001_0000;
      S_FIM_ACERTO:     s = 8'b0000_0101;
      S_FIM_ERRO:       s = 8'b0000_0011;
      S_FIM_TIMEOUT:    s = 8'b0000_0011;
      default:          s = 8'h00;
    endcase
    return s;
  endfunction

  assign estado_nxt = proximo(estado, iniciar, jogada, igual, fim_contagem,
                              fim_limite, timeout);

  // State register with outputs registered from the state being entered, so
  // each output is a clean Moore function of the current state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado  <= S_INICIAL;
      saida_q <= 8'h00;
`ifdef TIMEOUT_EN
      tmo_q   <= 1'b0;
`endif
    end else begin
      estado  <= estado_nxt;
      saida_q <= decodifica(estado_nxt);
`ifdef TIMEOUT_EN
      tmo_q   <= (estado_nxt == S_FIM_TIMEOUT);
`endif
    end
  end

  assign {zera_c, conta_c, zera_l, conta_l, registra, acertou, errou, pronto} = saida_q;
  assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_seq.sv
// tb/tb_unidade_controle_seq.sv - self-checking bench for unidade_controle_seq
module tb_unidade_controle_seq;

  localparam int T = 3000;
`ifdef TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0, jogada = 1'b0, igual = 1'b0, fim_contagem = 1'b0, fim_limite = 1'b0;
  logic zera_c, conta_c, zera_l, conta_l, registra, acertou, errou, pronto, db_timeout;
  logic [3:0] db_estado;

  unidade_controle_seq #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .fim_contagem(fim_contagem), .fim_limite(fim_limite),
    .zera_c(zera_c), .conta_c(conta_c), .zera_l(zera_l), .conta_l(conta_l),
    .registra(registra), .acertou(acertou), .errou(errou), .pronto(pronto),
    .db_timeout(db_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  wire [7:0] flags = {zera_c, conta_c, zera_l, conta_l, registra, acertou, errou, pronto};

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic ini, input logic jog, input logic ig,
                        input logic fc, input logic fl);
    iniciar = ini; jogada = jog; igual = ig; fim_contagem = fc; fim_limite = fl;
  endtask

  // Expected outputs per state code, straight from the state descriptions.
  function automatic logic [7:0] flags_of(input int code);
    case (code)
      1:       return 8'hA0;
      3:       return 8'h08;
      5:       return 8'h40;
      6:       return 8'h90;
      10:      return 8'h05;
      13, 14:  return 8'h03;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk_state(input string nm, input int code);
    chk({nm, "_estado"}, int'(db_estado), code);
    chk({nm, "_flags"}, int'(flags), int'(flags_of(code)));
    chk({nm, "_tmo"}, int'(db_timeout), (code == 13) ? 1 : 0);
  endtask

  // Game-level reference: current state code and cycles already spent waiting.
  int m_est;
  int m_wait;

  task automatic model_step(input bit ini, input bit jog, input bit ig, input bit fc, input bit fl);
    int n;
    n = 0;
    if (m_est == 0) n = ini ? 1 : 0;
    else if (m_est == 1) n = 2;
    else if (m_est == 2) begin
      if (jog) n = 3;
      else if (TMO_ON && (m_wait + 1 == T)) n = 13;
      else n = 2;
    end
    else if (m_est == 3) n = 4;
    else if (m_est == 4) n = !ig ? 14 : (!fc ? 5 : (!fl ? 6 : 10));
    else if (m_est == 5 || m_est == 6) n = 2;
    else if (m_est == 10 || m_est == 13 || m_est == 14) n = ini ? 1 : m_est;
    m_wait = (m_est == 2 && n == 2) ? m_wait + 1 : 0;
    m_est = n;
  endtask

  typedef struct {
    logic ini, jog, ig, fc, fl;
    int   est;
    logic [7:0] flg;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1,  8'hA0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2,  8'h00};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2,  8'h00};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2,  8'h00};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2,  8'h00};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3,  8'h08};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4,  8'h00};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6,  8'h90};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2,  8'h00};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3,  8'h08};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4,  8'h00};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5,  8'h40};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2,  8'h00};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3,  8'h08};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4,  8'h00};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 14, 8'h03};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 14, 8'h03};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1,  8'hA0};

    // Reset state
    #12;
    chk("rst_estado", int'(db_estado), 0);
    chk("rst_flags", int'(flags), 0);
    chk("rst_tmo", int'(db_timeout), 0);
    reset = 1'b1;
    step();
    chk("idle_hold", int'(db_estado), 0);

    // Directed vector table
    for (int i = 0; i < 18; i++) begin
      set_in(vecs[i].ini, vecs[i].jog, vecs[i].ig, vecs[i].fc, vecs[i].fl);
      step();
      chk($sformatf("vec%0d_estado", i), int'(db_estado), vecs[i].est);
      chk($sformatf("vec%0d_flags", i), int'(flags), int'(vecs[i].flg));
      chk($sformatf("vec%0d_tmo", i), int'(db_timeout), 0);
    end

    // Sixteen correct rounds, last one flagged by fim_limite
    set_in(0, 0, 0, 0, 0);
    step();
    chk("win_start", int'(db_estado), 2);
    for (int r = 0; r < 16; r++) begin
      set_in(0, 1, 0, 0, 0); step();
      chk($sformatf("win_r%0d_reg", r), int'(db_estado), 3);
      set_in(0, 0, 1, 1, (r == 15)); step();
      step();
      if (r < 15) begin
        chk($sformatf("win_r%0d_lim", r), int'(db_estado), 6);
        set_in(0, 0, 0, 0, 0); step();
      end
    end
    chk_state("win_final", 10);
    set_in(0, 0, 0, 0, 0); step();
    chk_state("win_hold", 10);
    set_in(1, 0, 0, 0, 0); step();
    chk_state("win_restart", 1);

    // Asynchronous reset in the middle of comparacao
    set_in(0, 0, 0, 0, 0); step();
    set_in(0, 1, 0, 0, 0); step();
    set_in(0, 0, 1, 0, 0); step();
    chk("pre_rst_cmp", int'(db_estado), 4);
    #2 reset = 1'b0;
    #1;
    chk_state("async_rst", 0);
    set_in(1, 0, 0, 0, 0);
    #3 reset = 1'b1;
    step();
    chk_state("rst_release", 1);

    // Timeout boundary
    set_in(0, 0, 0, 0, 0); step();
    chk("tmo_enter", int'(db_estado), 2);
    repeat (T - 1) step();
    chk("tmo_before", int'(db_estado), 2);
    step();
    if (TMO_ON) begin
      chk_state("tmo_fire", 13);
      set_in(1, 0, 0, 0, 0); step();
      set_in(0, 0, 0, 0, 0); step();
      chk("tmo_reenter", int'(db_estado), 2);
      repeat (T - 1) step();
    end else begin
      chk_state("no_tmo", 2);
    end
    set_in(0, 1, 0, 0, 0); step();
    chk_state("jog_wins", 3);
    set_in(0, 0, 0, 0, 0); step();
    step();
    chk_state("tmo_err", 14);

    // Randomized run against the reference model
    m_est = 14;
    m_wait = 0;
    for (int c = 0; c < 2500; c++) begin
      bit ini, jog, ig, fc, fl;
      if ($urandom_range(99) == 0) begin
        reset = 1'b0;
        #1;
        m_est = 0; m_wait = 0;
        chk($sformatf("rnd%0d_async", c), int'(db_estado), 0);
        step();
        reset = 1'b1;
        chk_state($sformatf("rnd%0d_rst", c), m_est);
      end else begin
        ini = ($urandom_range(9) == 0);
        jog = ($urandom_range(9) < 3);
        ig  = ($urandom_range(9) < 8);
        fc  = $urandom_range(1);
        fl  = ($urandom_range(9) < 3);
        set_in(ini, jog, ig, fc, fl);
        model_step(ini, jog, ig, fc, fl);
        step();
        chk_state($sformatf("rnd%0d", c), m_est);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
